store_narrow: RTL and testbench

Store-path byte-lane unit for the MIPS datapath: the write-side counterpart of the load-path sign extender. It narrows a 32-bit register value to a byte (SB), halfword (SH) or word (SW) and commits it to word-organised data memory. Sub-word stores use a read-modify-write sequence over a ready-handshaked memory port. It sits between the register-file read port and the data memory, and the control unit stalls on `busy`.

---
 rtl/store_narrow.sv | 110 +++++++++++
 tb/tb_store_narrow.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow.sv
// Store-path byte-lane unit: narrows a register value to SB/SH/SW and commits it to
// word-organised memory, using read-modify-write for sub-word stores.
module store_narrow (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn,
  input  logic        memReady,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  size_p0;
  logic [1:0]  off_p0;
  logic [31:0] data_p0;
  logic        mis_p0;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Big-endian lanes: offset 0 is the most significant byte/halfword.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    res[31:24] = data[7:0];
        2'd1:    res[23:16] = data[7:0];
        2'd2:    res[15:8]  = data[7:0];
        default: res[7:0]   = data[7:0];
      endcase
    end else if (off[1]) begin
      res[15:0] = data[15:0];
    end else begin
      res[31:16] = data[15:0];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_misaligned(size, addr[1:0])) state_nxt = DONE;
          else if (size == 2'b10)             state_nxt = WRITE;
          else                                state_nxt = READ;
        end
      end
      READ:    if (memReady) state_nxt = WRITE;
      WRITE:   if (memReady) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request latch and merged write word
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      memAddr    <= 32'd0;
      memDataOut <= 32'd0;
      mis_p0     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        memAddr <= {addr[31:2], 2'b00};
        mis_p0  <= is_misaligned(size, addr[1:0]);
        if (size == 2'b10) memDataOut <= dataIn;
      end else if (state == READ && memReady) begin
        memDataOut <= merge_lane(memDataIn, data_p0, size_p0, off_p0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      size_p0 <= size;
      off_p0  <= addr[1:0];
      data_p0 <= dataIn;
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign misaligned = (state == DONE) && mis_p0;
  assign memRead    = (state == READ);
  assign memWrite   = (state == WRITE);

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: directed vector table, wait-state/reset sequences and
// randomized stores checked against a byte-array memory model.
module tb_store_narrow;

  logic        clock, reset, start;
  logic [1:0]  size;
  logic [31:0] addr, dataIn;
  logic [31:0] memAddr, memDataOut, memDataIn;
  logic        memRead, memWrite, memReady;
  logic        busy, done, misaligned;

  store_narrow dut (
    .clock(clock), .reset(reset), .start(start), .size(size), .addr(addr),
    .dataIn(dataIn), .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .memReady(memReady),
    .busy(busy), .done(done), .misaligned(misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int rstall = 0, wstall = 0, rcnt = 0, wcnt = 0, commits = 0;

  // Memory responder: stalls a configurable number of cycles per request.
  always @(negedge clock) begin
    if (memRead) begin
      if (rcnt < rstall) begin memReady = 1'b0; rcnt++; end
      else memReady = 1'b1;
      memDataIn = mem[memAddr[9:2]];
    end else if (memWrite) begin
      if (wcnt < wstall) begin memReady = 1'b0; wcnt++; end
      else memReady = 1'b1;
      memDataIn = $urandom;
    end else begin
      memReady  = 1'($urandom_range(0, 1));
      memDataIn = $urandom;
      rcnt = 0;
      wcnt = 0;
    end
  end

  always @(posedge clock) begin
    if (!reset && memWrite && memReady) begin
      mem[memAddr[9:2]] = memDataOut;
      commits++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b [4];
    logic [31:0] res;
    int          k;
    for (int i = 0; i < 4; i++) b[i] = 8'(old >> (8 * (3 - i)));
    if (model_mis(sz, a)) return old;
    if (sz == 2'b00) begin
      k = int'(a % 4);
      b[k] = d[7:0];
    end else if (sz == 2'b01) begin
      k = int'(a % 4);
      b[k] = d[15:8];
      b[k + 1] = d[7:0];
    end else begin
      for (int i = 0; i < 4; i++) b[i] = 8'(d >> (8 * (3 - i)));
    end
    res = 32'd0;
    for (int i = 0; i < 4; i++) res = (res << 8) | 32'(b[i]);
    return res;
  endfunction

  int   r_lat, r_reads, r_first_wr;
  logic r_mis, r_to, r_overlap, r_addr_bad, r_dout_bad;

  task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input int rs, input int ws, input logic pulse);
    logic [31:0] dout0;
    @(negedge clock);
    chk("idle_before_start", {30'd0, busy, done}, 32'd0);
    rstall = rs; wstall = ws;
    start = 1'b1; size = sz; addr = a; dataIn = d;
    r_lat = 0; r_reads = 0; r_first_wr = -1;
    r_overlap = 1'b0; r_addr_bad = 1'b0; r_dout_bad = 1'b0; dout0 = 32'd0;
    @(negedge clock);
    start = 1'b0;
    dataIn = $urandom;
    r_lat = 1;
    while (!done && r_lat < 60) begin
      if (memRead && memWrite) r_overlap = 1'b1;
      if ((memRead || memWrite) && memAddr !== {a[31:2], 2'b00}) r_addr_bad = 1'b1;
      if (memRead) r_reads++;
      if (memWrite) begin
        if (r_first_wr < 0) begin r_first_wr = r_lat; dout0 = memDataOut; end
        else if (memDataOut !== dout0) r_dout_bad = 1'b1;
      end
      if (pulse) begin
        start = r_lat[0]; size = 2'b10; addr = 32'h180; dataIn = 32'h0BAD0BAD;
      end
      @(negedge clock);
      r_lat++;
    end
    start = 1'b0;
    r_to  = !done;
    r_mis = misaligned;
    if (done && (memRead || memWrite)) r_overlap = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] init;
    logic [31:0] expw;
    int          lat;
    logic        mis;
    int          wr_at;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [7:0]  idx;
    logic [1:0]  sz;
    logic [31:0] a, d, w0;
    int          rs, ws, exp_lat, c0;

    vt[0] = '{2'b10, 32'h100, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF, 2, 1'b0, 1};
    vt[1] = '{2'b00, 32'h101, 32'hFFFFFFAB, 32'h11223344, 32'h11AB3344, 3, 1'b0, 2};
    vt[2] = '{2'b00, 32'h103, 32'hFFFFFFAB, 32'h11223344, 32'h112233AB, 3, 1'b0, 2};
    vt[3] = '{2'b01, 32'h102, 32'h0000CAFE, 32'h11223344, 32'h1122CAFE, 3, 1'b0, 2};
    vt[4] = '{2'b00, 32'h100, 32'h12345678, 32'h11223344, 32'h78223344, 3, 1'b0, 2};
    vt[5] = '{2'b01, 32'h100, 32'hFFFF5A5A, 32'h11223344, 32'h5A5A3344, 3, 1'b0, 2};
    vt[6] = '{2'b00, 32'h102, 32'hABCDEFEE, 32'h11223344, 32'h1122EE44, 3, 1'b0, 2};
    vt[7] = '{2'b01, 32'h103, 32'h0000CAFE, 32'h11223344, 32'h11223344, 1, 1'b1, -1};
    vt[8] = '{2'b10, 32'h102, 32'hDEADBEEF, 32'h11223344, 32'h11223344, 1, 1'b1, -1};
    vt[9] = '{2'b11, 32'h100, 32'hDEADBEEF, 32'h11223344, 32'h11223344, 1, 1'b1, -1};

    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'd0; dataIn = 32'd0;
    memReady = 1'b0; memDataIn = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {27'd0, busy, done, misaligned, memRead, memWrite}, 32'd0);
    chk("reset_memAddr", memAddr, 32'd0);
    chk("reset_memDataOut", memDataOut, 32'd0);
    reset = 1'b0;

    // Directed vector table, memReady always high while strobing.
    for (int i = 0; i < 10; i++) begin
      mem[vt[i].a[9:2]] = vt[i].init;
      c0 = commits;
      run_store(vt[i].sz, vt[i].a, vt[i].d, 0, 0, 1'b0);
      chk($sformatf("vec%0d_timeout", i), {31'd0, r_to}, 32'd0);
      chk($sformatf("vec%0d_latency", i), r_lat, vt[i].lat);
      chk($sformatf("vec%0d_misaligned", i), {31'd0, r_mis}, {31'd0, vt[i].mis});
      chk($sformatf("vec%0d_word", i), mem[vt[i].a[9:2]], vt[i].expw);
      chk($sformatf("vec%0d_first_write", i), r_first_wr, vt[i].wr_at);
      chk($sformatf("vec%0d_reads", i), r_reads, (vt[i].mis || vt[i].sz == 2'b10) ? 0 : 1);
      chk($sformatf("vec%0d_commits", i), commits - c0, vt[i].mis ? 0 : 1);
      chk($sformatf("vec%0d_strobe_rules", i), {29'd0, r_overlap, r_addr_bad, r_dout_bad}, 32'd0);
      ref_mem[vt[i].a[9:2]] = mem[vt[i].a[9:2]];
    end

    // Wait states on both phases, with start pulses while busy.
    mem[8'h40] = 32'h11223344;
    w0 = mem[8'h60];
    c0 = commits;
    run_store(2'b00, 32'h101, 32'hFFFFFFAB, 2, 1, 1'b1);
    chk("wait_latency", r_lat, 6);
    chk("wait_word", mem[8'h40], 32'h11AB3344);
    chk("wait_reads", r_reads, 3);
    chk("wait_strobe_rules", {29'd0, r_overlap, r_addr_bad, r_dout_bad}, 32'd0);
    chk("wait_busy_start_ignored", mem[8'h60], w0);
    @(negedge clock);
    @(negedge clock);
    chk("wait_no_queued_request", {30'd0, busy, done}, 32'd0);
    chk("wait_commits", commits - c0, 1);
    ref_mem[8'h40] = mem[8'h40];
    ref_mem[8'h60] = mem[8'h60];

    // Reset while WRITE is stalled.
    mem[8'h50] = 32'hA5A5A5A5;
    wstall = 20;
    @(negedge clock);
    start = 1'b1; size = 2'b10; addr = 32'h140; dataIn = 32'h12345678;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 5 && !memWrite; k++) @(negedge clock);
    chk("rst_reached_write", {31'd0, memWrite}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_outputs", {27'd0, busy, done, misaligned, memRead, memWrite}, 32'd0);
    chk("rst_mid_memAddr", memAddr, 32'd0);
    chk("rst_mid_memDataOut", memDataOut, 32'd0);
    chk("rst_mid_no_write", mem[8'h50], 32'hA5A5A5A5);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_after_no_done", {31'd0, done}, 32'd0);
    run_store(2'b10, 32'h140, 32'hCAFEF00D, 0, 0, 1'b0);
    chk("rst_follow_latency", r_lat, 2);
    chk("rst_follow_word", mem[8'h50], 32'hCAFEF00D);
    ref_mem[8'h50] = mem[8'h50];

    // Randomized stores against the model, back to back.
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'h100 + 32'($urandom_range(0, 255));
      d  = $urandom;
      rs = $urandom_range(0, 3);
      ws = $urandom_range(0, 3);
      idx = a[9:2];
      ref_mem[idx] = model_store(ref_mem[idx], sz, a, d);
      if (model_mis(sz, a)) exp_lat = 1;
      else if (sz == 2'b10) exp_lat = 2 + ws;
      else exp_lat = 3 + rs + ws;
      run_store(sz, a, d, rs, ws, 1'b0);
      chk($sformatf("rand%0d_latency", n), r_lat, exp_lat);
      chk($sformatf("rand%0d_misaligned", n), {31'd0, r_mis}, {31'd0, model_mis(sz, a)});
      chk($sformatf("rand%0d_word", n), mem[idx], ref_mem[idx]);
      chk($sformatf("rand%0d_strobe_rules", n), {29'd0, r_overlap, r_addr_bad, r_dout_bad}, 32'd0);
    end

    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
